// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned multiplier: shift-and-add over one 8-bit adder,
// eight iterations per product, with a one-cycle done pulse.
module mul8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] p
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  m_q, m_d;
    logic [7:0]  q_q, q_d;
    logic [7:0]  a_q, a_d;
    logic        c_q, c_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] p_q, p_d;
    logic [8:0]  acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            a_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            a_q     <= a_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // C is always clear entering a RUN step (cleared on load and by each
    // shift), so {C,A} on the no-add path equals {0,A}.
    always_comb begin
        acc = q_q[0] ? ({1'b0, a_q} + {1'b0, m_q}) : {c_q, a_q};
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        a_d     = a_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    a_d     = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                c_d   = 1'b0;
                a_d   = acc[8:1];
                q_d   = {acc[0], q_q[7:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    p_d     = {acc[8:1], acc[0], q_q[7:1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign p    = p_q;

endmodule

// File: tb/tb_mul8_seq.sv
// Scoreboard bench for mul8_seq: stimulus pushes hand-computed products,
// a negedge monitor pops and compares on every done pulse.
module tb_mul8_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int unsigned n_done = 0;
    int unsigned base;
    logic [15:0] exp_q[$];
    logic [15:0] held_p;
    logic [15:0] e;
    bit          ok;

    logic [7:0]  va[3] = '{8'h12, 8'hA5, 8'h0F};
    logic [7:0]  vb[3] = '{8'h34, 8'h5A, 8'hF0};
    logic [15:0] ve[3] = '{16'h03A8, 16'h3A02, 16'h0E10};

    mul8_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: p=0x%04h with nothing outstanding", p);
            end else begin
                e = exp_q.pop_front();
                check("product", p, e);
            end
        end
    end

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] expv);
        int unsigned busy_cnt;
        int unsigned lat;
        busy_cnt = 0;
        lat      = 0;
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                a     = ~av;
                b     = ~bv;
            end
            if (i == 4) check("p_hold_in_run", p, held_p);
            if (busy) busy_cnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
        check("busy_cycles", 16'(busy_cnt), 16'd8);
        check("done_latency", 16'(lat), 16'd9);
        @(negedge clk);
        check("done_width", {15'b0, done}, 16'h0000);
        check("p_held_idle", p, expv);
        held_p = expv;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        held_p = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {15'b0, busy}, 16'h0000);
        check("reset_done", {15'b0, done}, 16'h0000);
        check("reset_p", p, 16'h0000);
        rst = 1'b0;

        run_op(8'h0D, 8'h0B, 16'h008F);
        run_op(8'hFF, 8'hFF, 16'hFE01);
        run_op(8'h00, 8'hFF, 16'h0000);
        run_op(8'h80, 8'h02, 16'h0100);

        // start re-asserted during busy and through the done cycle
        @(negedge clk);
        a     = 8'h03;
        b     = 8'h05;
        start = 1'b1;
        exp_q.push_back(16'h000F);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = 8'h07;
        b     = 8'h07;
        @(negedge clk);
        start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("ignore_start_done");
        @(negedge clk);
        start = 1'b0;
        base  = n_done;
        repeat (15) @(negedge clk);
        check("ignore_start_no_2nd_done", 16'(n_done - base), 16'd0);
        check("ignore_start_p", p, 16'h000F);
        held_p = 16'h000F;

        // back-to-back with start held high; operands scrambled mid-run
        @(negedge clk);
        a     = va[0];
        b     = vb[0];
        start = 1'b1;
        exp_q.push_back(ve[0]);
        for (int k = 0; k < 3; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (busy) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) timeout("b2b_busy");
            repeat (2) @(negedge clk);
            a = 8'hEE;
            b = 8'hEE;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) timeout("b2b_done");
            if (k < 2) begin
                a = va[k+1];
                b = vb[k+1];
                exp_q.push_back(ve[k+1]);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_p_held", p, 16'h0E10);
        held_p = 16'h0E10;

        // reset four RUN cycles into an operation
        @(negedge clk);
        a     = 8'h09;
        b     = 8'h09;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        base = n_done;
        check("midrun_rst_busy", {15'b0, busy}, 16'h0000);
        check("midrun_rst_done", {15'b0, done}, 16'h0000);
        check("midrun_rst_p", p, 16'h0000);
        held_p = 16'h0000;
        repeat (12) @(negedge clk);
        check("midrun_rst_no_done", 16'(n_done - base), 16'd0);
        run_op(8'h02, 8'h03, 16'h0006);

        // rst and start on the same edge
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h05;
        b     = 8'h05;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        base  = n_done;
        check("rst_start_busy", {15'b0, busy}, 16'h0000);
        check("rst_start_p", p, 16'h0000);
        repeat (12) @(negedge clk);
        check("rst_start_no_done", 16'(n_done - base), 16'd0);
        check("rst_start_idle", {15'b0, busy}, 16'h0000);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
